// File: rtl/dma_mch_sched.sv
// Purpose: multi-channel DMA scheduler; round-robin over enabled descriptors, one rd/wr command pair each.
// Latency: 1 cycle per SELECT decision; a command is presented the cycle after a channel is latched.
// Backpressure: rd/wr valids hold addr/bytes until each stream's own handshake; run ends only once axi_pend_i drops.
//
// Ports: clk/rst (async active-low); go_i/abort_i from CSR; desc_*_i flattened per-channel descriptors;
//        rd_*/wr_* stream command + done/err per streamer; axi_pend_i outstanding AXI traffic;
//        clear_o/active_o/done_o/err_o/err_ch_o/desc_done_o status to CSR.
module dma_mch_sched #(
   parameter  int NUM_CH  = 4,
   parameter  int ADDR_W  = 32,
   parameter  int BYTES_W = 32,
   localparam int CH_W    = $clog2(NUM_CH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        go_i,
   input  logic                        abort_i,
   input  logic [NUM_CH-1:0]           desc_en_i,
   input  logic [NUM_CH*ADDR_W-1:0]    desc_src_i,
   input  logic [NUM_CH*ADDR_W-1:0]    desc_dst_i,
   input  logic [NUM_CH*BYTES_W-1:0]   desc_bytes_i,
   output logic                        rd_valid_o,
   input  logic                        rd_ready_i,
   output logic [ADDR_W-1:0]           rd_addr_o,
   output logic [BYTES_W-1:0]          rd_bytes_o,
   input  logic                        rd_done_i,
   input  logic                        rd_err_i,
   output logic                        wr_valid_o,
   input  logic                        wr_ready_i,
   output logic [ADDR_W-1:0]           wr_addr_o,
   output logic [BYTES_W-1:0]          wr_bytes_o,
   input  logic                        wr_done_i,
   input  logic                        wr_err_i,
   input  logic                        axi_pend_i,
   output logic                        clear_o,
   output logic                        active_o,
   output logic                        done_o,
   output logic                        err_o,
   output logic [CH_W-1:0]             err_ch_o,
   output logic [NUM_CH-1:0]           desc_done_o
);

   localparam int CW1 = CH_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_DRAIN, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [CH_W-1:0]    rr_ptr, cur_ch;
   logic [ADDR_W-1:0]  cur_src, cur_dst;
   logic [BYTES_W-1:0] cur_bytes;
   logic               rd_pend, wr_pend;     // command not yet accepted
   logic               rd_seen, wr_seen;     // sticky done flags
   logic               active_q, done_q, err_q;
   logic [CH_W-1:0]    err_ch_q;
   logic [NUM_CH-1:0]  desc_done_q;

   // per-channel views of the flattened descriptor buses
   logic [ADDR_W-1:0]  src_arr   [NUM_CH];
   logic [ADDR_W-1:0]  dst_arr   [NUM_CH];
   logic [BYTES_W-1:0] bytes_arr [NUM_CH];

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         src_arr[k]   = desc_src_i[k*ADDR_W +: ADDR_W];
         dst_arr[k]   = desc_dst_i[k*ADDR_W +: ADDR_W];
         bytes_arr[k] = desc_bytes_i[k*BYTES_W +: BYTES_W];
      end
   end

   // cyclic search from rr_ptr for the first enabled, not-yet-done channel
   logic [CW1-1:0]  cand;
   logic            sel_found;
   logic [CH_W-1:0] sel_ch;

   always_comb begin
      cand      = '0;
      sel_found = 1'b0;
      sel_ch    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = {1'b0, rr_ptr} + CW1'(i);
         if (cand >= CW1'(NUM_CH)) cand = cand - CW1'(NUM_CH);
         if (!sel_found && desc_en_i[cand[CH_W-1:0]] && !desc_done_q[cand[CH_W-1:0]]) begin
            sel_found = 1'b1;
            sel_ch    = cand[CH_W-1:0];
         end
      end
   end

   // next-state and control strobes
   logic start_run, sel_skip, sel_take, ch_complete, err_hit, stream_err;
   logic rd_pend_nxt, wr_pend_nxt, rd_seen_nxt, wr_seen_nxt;

   always_comb begin
      state_nxt   = state;
      start_run   = 1'b0;
      sel_skip    = 1'b0;
      sel_take    = 1'b0;
      ch_complete = 1'b0;
      err_hit     = 1'b0;
      stream_err  = rd_err_i | wr_err_i;
      rd_pend_nxt = rd_pend;
      wr_pend_nxt = wr_pend;
      rd_seen_nxt = rd_seen | rd_done_i;
      wr_seen_nxt = wr_seen | wr_done_i;
      case (state)
         S_IDLE: begin
            if (go_i) begin
               start_run = 1'b1;
               state_nxt = S_SELECT;
            end
         end
         S_SELECT: begin
            if (abort_i || !sel_found) begin
               state_nxt = S_DRAIN;
            end else if (bytes_arr[sel_ch] == '0) begin
               // empty descriptor completes without touching the streamers
               sel_skip = 1'b1;
            end else begin
               sel_take  = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            rd_pend_nxt = rd_pend & ~rd_ready_i;
            wr_pend_nxt = wr_pend & ~wr_ready_i;
            if (stream_err) begin
               err_hit   = 1'b1;
               state_nxt = S_DRAIN;
            end else if (abort_i) begin
               state_nxt = S_DRAIN;
            end else if (!rd_pend_nxt && !wr_pend_nxt) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (stream_err) begin
               err_hit   = 1'b1;
               state_nxt = S_DRAIN;
            end else if (abort_i) begin
               state_nxt = S_DRAIN;
            end else if (rd_seen_nxt && wr_seen_nxt) begin
               ch_complete = 1'b1;
               state_nxt   = S_SELECT;
            end
         end
         S_DRAIN: begin
            if (!axi_pend_i) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr      <= '0;
         cur_ch      <= '0;
         cur_src     <= '0;
         cur_dst     <= '0;
         cur_bytes   <= '0;
         rd_pend     <= 1'b0;
         wr_pend     <= 1'b0;
         rd_seen     <= 1'b0;
         wr_seen     <= 1'b0;
         active_q    <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_ch_q    <= '0;
         desc_done_q <= '0;
      end else begin
         if (start_run) begin
            active_q    <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_ch_q    <= '0;
            desc_done_q <= '0;
         end
         if (sel_skip) desc_done_q[sel_ch] <= 1'b1;
         if (sel_take) begin
            cur_ch    <= sel_ch;
            cur_src   <= src_arr[sel_ch];
            cur_dst   <= dst_arr[sel_ch];
            cur_bytes <= bytes_arr[sel_ch];
            rd_pend   <= 1'b1;
            wr_pend   <= 1'b1;
            rd_seen   <= 1'b0;
            wr_seen   <= 1'b0;
         end
         if (state == S_ISSUE) begin
            rd_pend <= rd_pend_nxt;
            wr_pend <= wr_pend_nxt;
         end
         // done pulses are collected from ISSUE onward, so an early done is not lost
         if (state == S_ISSUE || state == S_WAIT) begin
            rd_seen <= rd_seen_nxt;
            wr_seen <= wr_seen_nxt;
         end
         if (ch_complete) begin
            desc_done_q[cur_ch] <= 1'b1;
            rr_ptr <= (cur_ch == CH_W'(NUM_CH-1)) ? '0 : cur_ch + 1'b1;
         end
         if (err_hit) begin
            err_q <= 1'b1;
            if (!err_q) err_ch_q <= cur_ch;
         end
         if (state == S_DONE) begin
            done_q   <= 1'b1;
            active_q <= 1'b0;
         end
      end
   end

   // valids are tied to ISSUE so an abort/error drops them on the state change
   assign rd_valid_o  = (state == S_ISSUE) && rd_pend;
   assign wr_valid_o  = (state == S_ISSUE) && wr_pend;
   assign rd_addr_o   = cur_src;
   assign wr_addr_o   = cur_dst;
   assign rd_bytes_o  = cur_bytes;
   assign wr_bytes_o  = cur_bytes;
   assign clear_o     = start_run;
   assign active_o    = active_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign err_ch_o    = err_ch_q;
   assign desc_done_o = desc_done_q;

endmodule

// File: tb/tb_dma_mch_sched.sv
// Purpose: self-checking bench for dma_mch_sched with streamer responders and a run-level model.
// Latency: responders return done a programmable number of cycles after each command handshake.
// Backpressure: command ready is immediate, random, or held low for one chosen channel.
module tb_dma_mch_sched;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int BW = 32;
   localparam int CW = 2;

   logic              clk, rst, go_i, abort_i;
   logic [N-1:0]      desc_en_i;
   logic [N*AW-1:0]   desc_src_i, desc_dst_i;
   logic [N*BW-1:0]   desc_bytes_i;
   logic              rd_valid_o, rd_ready_i, rd_done_i, rd_err_i;
   logic              wr_valid_o, wr_ready_i, wr_done_i, wr_err_i;
   logic [AW-1:0]     rd_addr_o, wr_addr_o;
   logic [BW-1:0]     rd_bytes_o, wr_bytes_o;
   logic              axi_pend_i, clear_o, active_o, done_o, err_o;
   logic [CW-1:0]     err_ch_o;
   logic [N-1:0]      desc_done_o;

   dma_mch_sched #(.NUM_CH(N), .ADDR_W(AW), .BYTES_W(BW)) dut (
      .clk(clk), .rst(rst), .go_i(go_i), .abort_i(abort_i),
      .desc_en_i(desc_en_i), .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i),
      .desc_bytes_i(desc_bytes_i),
      .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_addr_o(rd_addr_o),
      .rd_bytes_o(rd_bytes_o), .rd_done_i(rd_done_i), .rd_err_i(rd_err_i),
      .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
      .wr_bytes_o(wr_bytes_o), .wr_done_i(wr_done_i), .wr_err_i(wr_err_i),
      .axi_pend_i(axi_pend_i), .clear_o(clear_o), .active_o(active_o),
      .done_o(done_o), .err_o(err_o), .err_ch_o(err_ch_o), .desc_done_o(desc_done_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // responder configuration
   int rd_dly, wr_dly, rd_block_ch, err_ch_sel;
   bit rd_rand, wr_rand;
   int rd_cd, wr_cd, pend_cd, clr_cnt;
   bit wr_is_err;
   logic [AW-1:0] rd_log_addr[$], wr_log_addr[$];
   logic [BW-1:0] rd_log_bytes[$], wr_log_bytes[$];

   // descriptor table and model state
   logic [AW-1:0] t_src [N];
   logic [AW-1:0] t_dst [N];
   logic [BW-1:0] t_bytes [N];
   int            m_ptr;
   int            exp_q[$];
   logic [N-1:0]  exp_done;

   // read streamer: a handshake happens at the posedge after this negedge if valid & ready
   initial begin
      rd_cd = 0; rd_ready_i = 1'b1; rd_done_i = 1'b0; rd_err_i = 1'b0;
      forever begin
         @(negedge clk);
         rd_done_i = 1'b0;
         if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) rd_done_i = 1'b1;
         end
         rd_ready_i = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (rd_valid_o && rd_block_ch >= 0 && int'(rd_addr_o[3:0]) == rd_block_ch) rd_ready_i = 1'b0;
         if (rd_valid_o && rd_ready_i) begin
            rd_log_addr.push_back(rd_addr_o);
            rd_log_bytes.push_back(rd_bytes_o);
            rd_cd = rd_dly;
         end
      end
   end

   // write streamer, optionally failing on one channel and holding axi_pend for 10 cycles
   initial begin
      wr_cd = 0; pend_cd = 0; wr_is_err = 0;
      wr_ready_i = 1'b1; wr_done_i = 1'b0; wr_err_i = 1'b0; axi_pend_i = 1'b0;
      forever begin
         @(negedge clk);
         wr_done_i = 1'b0;
         wr_err_i  = 1'b0;
         if (pend_cd > 0) begin
            pend_cd--;
            if (pend_cd == 0) axi_pend_i = 1'b0;
         end
         if (wr_cd > 0) begin
            wr_cd--;
            if (wr_cd == 0) begin
               if (wr_is_err) begin
                  wr_err_i = 1'b1; axi_pend_i = 1'b1; pend_cd = 10;
               end else begin
                  wr_done_i = 1'b1;
               end
            end
         end
         wr_ready_i = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         if (wr_valid_o && wr_ready_i) begin
            wr_log_addr.push_back(wr_addr_o);
            wr_log_bytes.push_back(wr_bytes_o);
            wr_is_err = (err_ch_sel >= 0) && (int'(wr_addr_o[3:0]) == err_ch_sel);
            wr_cd = wr_dly;
         end
      end
   end

   initial begin
      clr_cnt = 0;
      forever begin
         @(negedge clk);
         #3;
         if (clear_o) clr_cnt++;
      end
   end

   // Channel k's addresses carry k in the low nibble so logged commands identify their channel.
   task automatic set_desc(input logic [N-1:0] zero_mask, input int fixed_bytes);
      for (int k = 0; k < N; k++) begin
         t_src[k] = ($urandom() & 32'hFFFF_FF00) | 32'(k);
         t_dst[k] = ($urandom() & 32'hFFFF_FF00) | 32'h80 | 32'(k);
         if (zero_mask[k])         t_bytes[k] = '0;
         else if (fixed_bytes > 0) t_bytes[k] = 32'(fixed_bytes);
         else                      t_bytes[k] = 32'($urandom_range(1, 4096));
         desc_src_i[k*AW +: AW]   = t_src[k];
         desc_dst_i[k*AW +: AW]   = t_dst[k];
         desc_bytes_i[k*BW +: BW] = t_bytes[k];
      end
   endtask

   // Run-level model: walk channels cyclically from the persistent pointer; an empty
   // descriptor finishes silently; stop_ch is issued but never completes (error/abort).
   task automatic model_run(input logic [N-1:0] en, input int stop_ch);
      bit fin [N];
      int p, sel, c;
      bit found;
      for (int k = 0; k < N; k++) fin[k] = 0;
      exp_q.delete();
      p = m_ptr;
      for (int step = 0; step < 2 * N; step++) begin
         found = 0; sel = 0;
         for (int k = 0; k < N; k++) begin
            c = (p + k) % N;
            if (!found && en[c] && !fin[c]) begin found = 1; sel = c; end
         end
         if (!found) break;
         if (t_bytes[sel] == 0) begin
            fin[sel] = 1;
            continue;
         end
         exp_q.push_back(sel);
         if (sel == stop_ch) break;
         fin[sel] = 1;
         p = (sel + 1) % N;
      end
      for (int k = 0; k < N; k++) exp_done[k] = fin[k];
      m_ptr = p;
   endtask

   task automatic do_run(input string tag, input logic [N-1:0] en, input int stop_ch,
                         input bit do_abort, input bit exp_err, input bit mid_go);
      int cyc, viol, nr, nw;
      bit arm;
      model_run(en, stop_ch);
      @(negedge clk);
      desc_en_i = en;
      rd_log_addr.delete(); rd_log_bytes.delete();
      wr_log_addr.delete(); wr_log_bytes.delete();
      clr_cnt = 0;
      abort_i = 1'b0;
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      cyc = 0; viol = 0; arm = 0;
      while (cyc < 3000) begin
         #3;
         if (done_o && axi_pend_i) viol++;
         if (err_o && (rd_valid_o || wr_valid_o)) viol++;
         if (done_o) break;
         if (do_abort && !arm && rd_log_addr.size() > 0 && wr_log_addr.size() > 0)
            if (rd_log_addr[$][3:0] == 4'd2 && wr_log_addr[$][3:0] == 4'd2) arm = 1;
         @(negedge clk);
         cyc++;
         if (arm) abort_i = 1'b1;
         if (mid_go) go_i = (cyc == 15);
      end
      abort_i = 1'b0;
      go_i = 1'b0;
      check({tag, " done_in_time"}, 64'(cyc < 3000), 64'd1);
      check({tag, " done_o"}, 64'(done_o), 64'd1);
      check({tag, " active_o"}, 64'(active_o), 64'd0);
      check({tag, " err_o"}, 64'(err_o), 64'(exp_err));
      if (exp_err) check({tag, " err_ch_o"}, 64'(err_ch_o), 64'(stop_ch));
      check({tag, " desc_done_o"}, 64'(desc_done_o), 64'(exp_done));
      check({tag, " clear_pulses"}, 64'(clr_cnt), 64'd1);
      check({tag, " protocol"}, 64'(viol), 64'd0);
      check({tag, " rd_cmds"}, 64'(rd_log_addr.size()), 64'(exp_q.size()));
      check({tag, " wr_cmds"}, 64'(wr_log_addr.size()), 64'(exp_q.size()));
      nr = (rd_log_addr.size() < exp_q.size()) ? rd_log_addr.size() : exp_q.size();
      nw = (wr_log_addr.size() < exp_q.size()) ? wr_log_addr.size() : exp_q.size();
      for (int i = 0; i < nr; i++) begin
         check({tag, " rd_addr"}, 64'(rd_log_addr[i]), 64'(t_src[exp_q[i]]));
         check({tag, " rd_bytes"}, 64'(rd_log_bytes[i]), 64'(t_bytes[exp_q[i]]));
      end
      for (int i = 0; i < nw; i++) begin
         check({tag, " wr_addr"}, 64'(wr_log_addr[i]), 64'(t_dst[exp_q[i]]));
         check({tag, " wr_bytes"}, 64'(wr_log_bytes[i]), 64'(t_bytes[exp_q[i]]));
      end
   endtask

   initial begin
      rst = 1'b0; go_i = 1'b0; abort_i = 1'b0; desc_en_i = '0;
      desc_src_i = '0; desc_dst_i = '0; desc_bytes_i = '0;
      rd_dly = 5; wr_dly = 5; rd_block_ch = -1; err_ch_sel = -1;
      rd_rand = 0; wr_rand = 0; m_ptr = 0;

      repeat (3) @(negedge clk);
      #3;
      check("reset valids", 64'({rd_valid_o, wr_valid_o}), 64'd0);
      check("reset status", 64'({clear_o, active_o, done_o, err_o, err_ch_o}), 64'd0);
      check("reset desc_done", 64'(desc_done_o), 64'd0);
      check("reset addr", 64'({rd_addr_o, wr_addr_o}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // in-order run, then repeat; then a partial mask shifting the pointer
      set_desc(4'b0000, 64);
      do_run("run_all", 4'b1111, -1, 0, 0, 0);
      do_run("run_again", 4'b1111, -1, 0, 0, 0);
      do_run("run_0110", 4'b0110, -1, 0, 0, 0);
      do_run("run_from3", 4'b1111, -1, 0, 0, 0);

      // zero-byte descriptor completes without a command
      set_desc(4'b0100, 0);
      do_run("run_zero", 4'b0101, -1, 0, 0, 0);

      // write error on ch1 with AXI traffic still draining
      set_desc(4'b0000, 0);
      err_ch_sel = 1;
      do_run("run_err", 4'b1111, 1, 0, 1, 0);
      err_ch_sel = -1;
      repeat (5) @(negedge clk);

      // abort while waiting on ch2, ch3 would be backpressured
      rd_dly = 12; wr_dly = 12; rd_block_ch = 3;
      do_run("run_abort", 4'b1111, 2, 1, 0, 0);
      rd_block_ch = -1;
      repeat (20) @(negedge clk);

      // done ordering: write first, then simultaneous; stray go mid-run
      rd_dly = 8; wr_dly = 5;
      do_run("run_wr_first", 4'b1111, -1, 0, 0, 1);
      rd_dly = 5; wr_dly = 5;
      do_run("run_same", 4'b1111, -1, 0, 0, 0);

      // randomized runs
      rd_rand = 1; wr_rand = 1;
      for (int r = 0; r < 8; r++) begin
         rd_dly = $urandom_range(1, 6);
         wr_dly = $urandom_range(1, 6);
         set_desc(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)), 0);
         do_run("run_rand", 4'($urandom_range(0, 15)), -1, 0, 0, 0);
      end
      rd_rand = 0; wr_rand = 0;
      rd_dly = 5; wr_dly = 5;

      // asynchronous reset in the middle of a run
      set_desc(4'b0000, 0);
      @(negedge clk);
      desc_en_i = 4'b1111;
      go_i = 1'b1;
      @(negedge clk);
      go_i = 1'b0;
      repeat (9) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midrst valids", 64'({rd_valid_o, wr_valid_o}), 64'd0);
      check("midrst status", 64'({active_o, done_o, err_o}), 64'd0);
      check("midrst desc_done", 64'(desc_done_o), 64'd0);
      m_ptr = 0;
      @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      do_run("run_after_rst", 4'b1111, -1, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_mch_sched.md
Name: dma_mch_sched

Overview:
- Parametrised multi-channel successor to the single-run DMA control FSM.
- Arbitrates NUM_CH descriptors round-robin, issues one read/write stream command pair per descriptor to the rd/wr streamers, and tracks completion per channel.
- Handles abort and streamer errors, drains outstanding AXI traffic, and reports status to the CSR block.
- Sits between the CSR bank and the dma_streamer pair, inside the DMA functional wrapper.

Parameters:
- NUM_CH, 4, number of descriptor channels (2..16).
- ADDR_W, 32, address width of src/dst.
- BYTES_W, 32, width of the byte-count field.
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- go_i  in  1  start pulse from CSR.
- abort_i  in  1  abort request level from CSR.
- desc_en_i  in  NUM_CH  per-channel enable.
- desc_src_i  in  NUM_CH*ADDR_W  per-channel source address; channel k at [k*ADDR_W +: ADDR_W].
- desc_dst_i  in  NUM_CH*ADDR_W  per-channel destination address.
- desc_bytes_i  in  NUM_CH*BYTES_W  per-channel byte count.
- rd_valid_o  out  1  read stream command valid.
- rd_ready_i  in  1  read streamer accepts command.
- rd_addr_o  out  ADDR_W  read start address.
- rd_bytes_o  out  BYTES_W  read byte count.
- rd_done_i  in  1  read stream complete pulse.
- rd_err_i  in  1  read stream error pulse.
- wr_valid_o, wr_ready_i, wr_addr_o, wr_bytes_o, wr_done_i, wr_err_i: same as rd_* for the write stream.
- axi_pend_i  in  1  AXI transactions outstanding.
- clear_o  out  1  one-cycle FIFO/IF clear pulse.
- active_o  out  1  run in progress.
- done_o  out  1  run finished (sticky).
- err_o  out  1  run ended with streamer error (sticky).
- err_ch_o  out  CH_W  channel that produced the first error.
- desc_done_o  out  NUM_CH  per-channel completion flags.

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr 0.
- Descriptor inputs are sampled only when a channel is selected; src/dst/bytes are latched on entry to ISSUE.
- IDLE:
  - go_i=1 accepts a run: clear_o=1 that cycle.
  - Also clears done_o, err_o, err_ch_o and desc_done_o, sets active_o (registered, visible next cycle), and moves to SELECT.
  - go_i is ignored in every state other than IDLE.
- SELECT (1 cycle per decision):
  - Search cyclically from rr_ptr for the first channel with desc_en=1 and desc_done=0.
  - None found -> DRAIN.
  - Selected channel has bytes==0 -> set its desc_done, stay in SELECT; no command is issued.
  - Otherwise latch the channel and go to ISSUE.
- ISSUE:
  - rd_valid_o and wr_valid_o rise together; each drops the cycle after its own valid&ready handshake.
  - valid, addr and bytes stay stable until the handshake.
  - Both accepted -> WAIT.
- WAIT:
  - rd_done_i and wr_done_i are captured in separate sticky flags; the two may arrive in any order or the same cycle.
  - A done pulse arriving during ISSUE is also captured.
  - Both flags set -> set desc_done[ch], rr_ptr = (ch+1) mod NUM_CH, return to SELECT.
- Error (rd_err_i or wr_err_i in ISSUE/WAIT):
  - Set err_o, record err_ch_o (first error only), deassert both valids, go to DRAIN.
  - desc_done of the failing channel stays 0.
- Abort (abort_i=1 in SELECT/ISSUE/WAIT): deassert valids, go to DRAIN; err_o is not set.
- DRAIN: hold until axi_pend_i==0, then DONE.
- DONE (1 cycle): done_o=1, active_o=0, go to IDLE; done_o and err_o stay set until the next go.
- Simultaneous error and abort: error wins (err_o set).
- rr_ptr persists across runs and is cleared only by reset.
- Async reset mid-run: all state returns to reset values immediately; no drain.

Test Plan:
- NUM_CH=4, en=4'b1111, bytes=64 each, streamers ack immediately with done after 5 cycles -> commands issued in channel order 0,1,2,3; desc_done_o=4'hF; done_o=1; err_o=0; exactly one clear_o pulse.
- Second go after the first run (rr_ptr=0 after ch3) versus a run with en=4'b0110 (rr_ptr=3 after ch2) -> the en=4'b0110 run services ch1 then ch2; the next run starts its search at ch3.
- en=4'b0101, bytes[2]=0 -> ch0 is issued, ch2 gets desc_done with no rd_valid/wr_valid; desc_done_o=4'b0101.
- wr_err_i pulse on ch1 while axi_pend_i=1 for 10 more cycles -> valids low; done_o rises after axi_pend_i falls; err_o=1; err_ch_o=1; desc_done_o[1]=0.
- abort_i during WAIT on ch2 with rd_ready held low on a later channel -> no further commands; done_o=1; err_o=0.
- wr_done_i arrives 3 cycles before rd_done_i, and a second case with both in the same cycle -> each descriptor completes once; go_i pulsed mid-run is ignored.
